// File: rtl/img_jpeg_pkg.sv
// ---------------------------------------------------------------------------
// img_jpeg_pkg
// Shared constants for the JPEG decode-side dequantise / un-zigzag path.
//   ZZ[k]    : raster position (row*8+col) of zigzag index k
//   QTAB[r]  : standard JPEG luminance quantisation table, raster order
//   sat_signed(x, w) : clamp a signed value to the w-bit two's complement range
// ---------------------------------------------------------------------------
package img_jpeg_pkg;

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  localparam logic [7:0] QTAB [64] = '{
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };

  // Clamp x to [-2^(w-1), 2^(w-1)-1]; valid for 1 <= w <= 31.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] x,
                                                    input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/img_dequant_sat.sv
// ---------------------------------------------------------------------------
// img_dequant_sat
// Combinational dequantiser: signed coefficient times unsigned table entry,
// saturated back to the coefficient width.
//   coef_i [DW] : signed quantised coefficient
//   q_i    [QW] : unsigned quantisation step
//   deq_o  [DW] : saturated signed product
// DW+QW+1 must not exceed 32 (saturation helper works on 32-bit values).
// ---------------------------------------------------------------------------
module img_dequant_sat
  import img_jpeg_pkg::*;
#(
  parameter int DW = 16,
  parameter int QW = 8
) (
  input  logic [DW-1:0] coef_i,
  input  logic [QW-1:0] q_i,
  output logic [DW-1:0] deq_o
);

  localparam int PW = DW + QW + 1;

  logic signed [PW-1:0] coef_ext;
  logic signed [PW-1:0] q_ext;
  logic signed [PW-1:0] prod;

  // Both operands widened to the full product width so the multiply is exact.
  assign coef_ext = {{(QW + 1){coef_i[DW-1]}}, coef_i};
  assign q_ext    = {{DW{1'b0}}, q_i};
  assign prod     = coef_ext * q_ext;
  assign deq_o    = DW'(sat_signed(32'(prod), DW));

endmodule

// File: rtl/img_jpeg_dequant_unzigzag.sv
// ---------------------------------------------------------------------------
// img_jpeg_dequant_unzigzag
// Accepts 64 quantised coefficients per 8x8 block in zigzag order, dequantises
// each with the luminance table, stores it at its raster position and streams
// the block out row-major. Two ping-pong banks let one block load while the
// other drains.
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_valid/s_ready   : input handshake, s_data = zigzag-ordered coefficient
//   m_valid/m_ready   : output handshake, m_data = raster-ordered coefficient
//   m_last            : marks raster index 63 of each block
// ---------------------------------------------------------------------------
module img_jpeg_dequant_unzigzag
  import img_jpeg_pkg::*;
#(
  parameter int DW = 16,
  parameter int QW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last
);

  logic [DW-1:0] bank_q [2][64];
  logic [1:0]    full_q,    full_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [5:0]    wr_idx_q,  wr_idx_d;
  logic [5:0]    rd_idx_q,  rd_idx_d;

  logic          wr_fire;
  logic          rd_fire;
  logic [5:0]    wr_raster;
  logic [QW-1:0] wr_qstep;
  logic [DW-1:0] wr_deq;

  assign s_ready   = !full_q[wr_bank_q];
  assign m_valid   = full_q[rd_bank_q];
  assign m_data    = bank_q[rd_bank_q][rd_idx_q];
  assign m_last    = m_valid && (rd_idx_q == 6'd63);

  assign wr_fire   = s_valid && s_ready;
  assign rd_fire   = m_valid && m_ready;
  assign wr_raster = ZZ[wr_idx_q];
  assign wr_qstep  = QW'(QTAB[wr_raster]);

  img_dequant_sat #(
    .DW(DW),
    .QW(QW)
  ) u_sat (
    .coef_i(s_data),
    .q_i   (wr_qstep),
    .deq_o (wr_deq)
  );

  // Writer only targets a non-full bank and reader only a full one, so the
  // set and clear below always touch different flags and both take effect.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    if (wr_fire) begin
      wr_idx_d = wr_idx_q + 6'd1;
      if (wr_idx_q == 6'd63) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end
    if (rd_fire) begin
      rd_idx_d = rd_idx_q + 6'd1;
      if (rd_idx_q == 6'd63) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned i = 0; i < 64; i++) begin
          bank_q[b][i] <= '0;
        end
      end
    end else if (wr_fire) begin
      bank_q[wr_bank_q][wr_raster] <= wr_deq;
    end
  end

endmodule

// File: tb/tb_img_jpeg_dequant_unzigzag.sv
module tb_img_jpeg_dequant_unzigzag;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;

  img_jpeg_dequant_unzigzag #(
    .DW(16),
    .QW(8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_last (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference tables, written out independently of the design package.
  int ZZ_T [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
  int Q_T [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,   12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,   14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68,109,103, 77,   24, 35, 55, 64, 81,104,113, 92,
    49, 64, 78, 87,103,121,120,101,   72, 92, 95, 98,112,100,103, 99};

  typedef struct {
    int zz;
    int val;
    int raster;
    int expv;
  } vec_t;

  vec_t vecs [11];

  int n_cmp = 0;
  int n_err = 0;
  int in_cnt, out_cnt;
  int in_blk [64];
  int out_buf [64];
  int exp_q [$];
  logic stall_pend;
  logic [15:0] stall_data;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int model(input int k, input int v);
    int p;
    p = v * Q_T[ZZ_T[k]];
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    return p;
  endfunction

  // One clock: drive, observe handshakes, advance to posedge+1.
  task automatic cycle(input logic sv, input int sd, input logic mr);
    int r [64];
    s_valid = sv;
    s_data  = sd[15:0];
    m_ready = mr;
    #1;
    if (m_valid) begin
      if (stall_pend) chk("stall_data", int'($signed(m_data)), int'($signed(stall_data)));
      if (m_ready) begin
        out_buf[out_cnt % 64] = int'($signed(m_data));
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          chk($sformatf("data[%0d]", out_cnt), int'($signed(m_data)), exp_q.pop_front());
        end
        chk("last", int'(m_last), (out_cnt % 64 == 63) ? 1 : 0);
        out_cnt++;
      end
    end else if (stall_pend) begin
      chk("stall_valid_drop", 0, 1);
    end
    stall_pend = m_valid && !m_ready;
    stall_data = m_data;
    if (sv && s_ready) begin
      in_blk[in_cnt % 64] = int'($signed(sd[15:0]));
      in_cnt++;
      if (in_cnt % 64 == 0) begin
        for (int k = 0; k < 64; k++) r[ZZ_T[k]] = model(k, in_blk[k]);
        for (int i = 0; i < 64; i++) exp_q.push_back(r[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 400) begin
      cycle(1'b0, 0, 1'b1);
      g++;
    end
    chk({nm, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic clear_model();
    in_cnt = 0;
    out_cnt = 0;
    exp_q.delete();
    stall_pend = 1'b0;
  endtask

  int base_in, base_out, g, nz, v;

  initial begin
    vecs[0]  = '{0,     3,  0,     48};
    vecs[1]  = '{1,     1,  1,     11};
    vecs[2]  = '{2,    -2,  8,    -24};
    vecs[3]  = '{63,   63, 63,   6237};
    vecs[4]  = '{63,  400, 63,  32767};
    vecs[5]  = '{63, -400, 63, -32768};
    vecs[6]  = '{5,     7,  2,     70};
    vecs[7]  = '{10,   -5, 32,    -90};
    vecs[8]  = '{35,  100, 56,   7200};
    vecs[9]  = '{20, -1000, 40, -24000};
    vecs[10] = '{42,  2000, 15,  32767};

    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    rst_n   = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", int'(s_ready), 1);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_last",  int'(m_last), 0);
    chk("rst_m_data",  int'(m_data), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single block: latency and m_last placement.
    for (int k = 0; k < 64; k++) begin
      chk("lat_m_valid_low", int'(m_valid), 0);
      v = (k == 0) ? 3 : (k == 1) ? 1 : (k == 2) ? -2 : 0;
      cycle(1'b1, v, 1'b1);
    end
    chk("lat_m_valid_high", int'(m_valid), 1);
    chk("lat_first_data", int'($signed(m_data)), 48);
    drain("single");
    chk("single_out1", out_buf[1], 11);
    chk("single_out8", out_buf[8], -24);

    // Hand-computed single-coefficient vectors.
    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < 64; k++) cycle(1'b1, (k == vecs[i].zz) ? vecs[i].val : 0, 1'b1);
      drain($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_value", i), out_buf[vecs[i].raster], vecs[i].expv);
      nz = 0;
      for (int r = 0; r < 64; r++) if (r != vecs[i].raster && out_buf[r] != 0) nz++;
      chk($sformatf("vec%0d_others_zero", i), nz, 0);
    end

    // Zigzag sweep: value k at zigzag index k.
    for (int k = 0; k < 64; k++) cycle(1'b1, k, 1'b1);
    drain("sweep");
    chk("sweep_r63", out_buf[63], 6237);
    chk("sweep_r8", out_buf[8], 24);

    // Backpressure: three blocks with m_ready low.
    base_in = in_cnt;
    g = 0;
    while (in_cnt < base_in + 128 && g < 300) begin
      cycle(1'b1, int'($urandom_range(0, 600)) - 300, 1'b0);
      g++;
    end
    chk("bp_accepted", in_cnt - base_in, 128);
    chk("bp_s_ready_low", int'(s_ready), 0);
    repeat (3) cycle(1'b1, 5, 1'b0);
    chk("bp_in_held", in_cnt - base_in, 128);
    base_out = out_cnt;
    g = 0;
    while (out_cnt < base_out + 64 && g < 200) begin
      chk("bp_s_ready_during_drain", int'(s_ready), 0);
      cycle(1'b1, int'($urandom_range(0, 600)) - 300, 1'b1);
      g++;
    end
    chk("bp_s_ready_returns", int'(s_ready), 1);
    g = 0;
    while ((in_cnt < base_in + 192 || exp_q.size() > 0) && g < 1000) begin
      cycle(in_cnt < base_in + 192, int'($urandom_range(0, 600)) - 300, 1'b1);
      g++;
    end
    chk("bp_in_total", in_cnt - base_in, 192);
    chk("bp_out_total", out_cnt - base_out, 192);

    // Random handshake toggling over ten blocks.
    base_in = in_cnt;
    base_out = out_cnt;
    g = 0;
    while ((in_cnt < base_in + 640 || exp_q.size() > 0) && g < 5000) begin
      cycle((in_cnt < base_in + 640) && ($urandom_range(0, 1) == 1),
            int'($urandom_range(0, 2000)) - 1000, $urandom_range(0, 1) == 1);
      g++;
    end
    chk("rand_in_total", in_cnt - base_in, 640);
    chk("rand_out_total", out_cnt - base_out, 640);

    // Reset mid-block.
    for (int k = 0; k < 30; k++) cycle(1'b1, 7, 1'b1);
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", int'(m_valid), 0);
    chk("midrst_s_ready", int'(s_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_m_valid_hold", int'(m_valid), 0);
    clear_model();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 64; k++) cycle(1'b1, (k == 0) ? 5 : 0, 1'b1);
    drain("postrst");
    chk("postrst_out0", out_buf[0], 80);
    chk("postrst_out1", out_buf[1], 0);
    chk("postrst_count", out_cnt, 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
